// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipeline.
// Contents:
//   MODE_SEXT/ZEXT/UPPER/BRANCH : 2-bit extension mode codes carried on in_mode_i
//   state_e                     : occupancy state of the out register + skid register
package imm_ext_pkg;

    localparam logic [1:0] MODE_SEXT   = 2'b00;
    localparam logic [1:0] MODE_ZEXT   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    // EMPTY: nothing held; BUSY: out register holds a beat; FULL: out and skid both hold a beat
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

endpackage : imm_ext_pkg

// File: rtl/imm_ext_core.sv
// Combinational immediate extender.
// Ports:
//   imm_i  [IN_W-1:0]  raw immediate field
//   mode_i [1:0]       extension mode (SEXT, ZEXT, UPPER, BRANCH)
//   data_o [OUT_W-1:0] extended immediate
// OUT_W >= IN_W+2 is checked by the instantiating top level.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm_i,
    input  logic [1:0]       mode_i,
    output logic [OUT_W-1:0] data_o
);

    localparam int S = OUT_W - IN_W;

    logic [OUT_W-1:0] sext_s;
    logic [OUT_W-1:0] zext_s;
    logic [OUT_W-1:0] upper_s;
    logic [OUT_W-1:0] branch_s;

    assign sext_s   = {{S{imm_i[IN_W-1]}}, imm_i};
    assign zext_s   = {{S{1'b0}}, imm_i};
    assign upper_s  = {imm_i, {S{1'b0}}};
    // The top two bits dropped here are sign copies, so nothing significant is lost.
    assign branch_s = {sext_s[OUT_W-3:0], 2'b00};

    // Select the extension result for the requested mode
    always_comb begin
        data_o = '0;
        case (mode_i)
            MODE_SEXT:   data_o = sext_s;
            MODE_ZEXT:   data_o = zext_s;
            MODE_UPPER:  data_o = upper_s;
            MODE_BRANCH: data_o = branch_s;
            default:     data_o = '0;
        endcase
    end

endmodule : imm_ext_core

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-generation unit with valid/ready on both sides and a
// one-entry skid register behind the output register (2 beats of storage).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid_i/in_ready_o input handshake (in_ready_o is registered)
//   in_imm_i [IN_W-1:0]   raw immediate
//   in_mode_i [1:0]       extension mode
//   in_tag_i [TAG_W-1:0]  sideband tag, passed through unchanged
//   out_valid_o/out_ready_i output handshake
//   out_data_o [OUT_W-1:0] extended immediate
//   out_tag_o [TAG_W-1:0] tag belonging to out_data_o
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  in_imm_i,
    input  logic [1:0]       in_mode_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic [TAG_W-1:0] out_tag_o
);

    if (OUT_W < IN_W + 2) begin : g_width_check
        $error("imm_ext_pipe: OUT_W must be at least IN_W+2");
    end

    state_e           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [OUT_W-1:0] skid_data_q;
    logic [TAG_W-1:0] skid_tag_q;

    // Extension is done on the input side so both storage registers hold final values.
    logic [OUT_W-1:0] ext_d;
    logic             accept_s;
    logic             take_s;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm_i  (in_imm_i),
        .mode_i (in_mode_i),
        .data_o (ext_d)
    );

    assign accept_s = in_valid_i & in_ready_q;
    assign take_s   = out_valid_q & out_ready_i;

    // Occupancy FSM driving the out register, skid register and both handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        out_data_q  <= ext_d;
                        out_tag_q   <= in_tag_i;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_BUSY;
                    end else begin
                        state_q     <= ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (accept_s && take_s) begin
                        out_data_q  <= ext_d;
                        out_tag_q   <= in_tag_i;
                        state_q     <= ST_BUSY;
                    end else if (take_s) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end else if (accept_s) begin
                        // Downstream stalled: park the new beat and stop accepting.
                        skid_data_q <= ext_d;
                        skid_tag_q  <= in_tag_i;
                        in_ready_q  <= 1'b0;
                        state_q     <= ST_FULL;
                    end else begin
                        state_q     <= ST_BUSY;
                    end
                end
                ST_FULL: begin
                    if (take_s) begin
                        out_data_q  <= skid_data_q;
                        out_tag_q   <= skid_tag_q;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_BUSY;
                    end else begin
                        state_q     <= ST_FULL;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_EMPTY;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_tag_o   = out_tag_q;

endmodule : imm_ext_pipe

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe (IN_W=16, OUT_W=32, TAG_W=5).
module tb_imm_ext_pipe;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  tag;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready_o;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid_o;
    logic        out_ready;
    logic [31:0] out_data_o;
    logic [4:0]  out_tag_o;

    int   n_chk;
    int   n_fail;
    int   n_out;
    int   last_wait;
    exp_t exp_q[$];

    imm_ext_pipe #(
        .IN_W  (16),
        .OUT_W (32),
        .TAG_W (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_o),
        .in_imm_i    (in_imm),
        .in_mode_i   (in_mode),
        .in_tag_i    (in_tag),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready),
        .out_data_o  (out_data_o),
        .out_tag_o   (out_tag_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [15:0] imm, input logic [1:0] mode,
                        input logic [4:0] tag, input logic [31:0] exp);
        bit done;
        exp_t e;
        done = 1'b0;
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
        last_wait = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready_o) begin
                e.data = exp;
                e.tag  = tag;
                exp_q.push_back(e);
                done = 1'b1;
            end else begin
                last_wait++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycles(1);
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    // Monitor: compares each taken beat against the scoreboard and checks hold stability
    initial begin
        exp_t        e;
        bit          hold_v;
        logic [31:0] hold_d;
        logic [4:0]  hold_t;
        hold_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 1'b0;
            end else if (out_valid_o && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%08h tag %0d, expected no beat",
                             out_data_o, out_tag_o);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data_o, e.data);
                    check("out_tag", {27'd0, out_tag_o}, {27'd0, e.tag});
                end
                hold_v = 1'b0;
            end else if (out_valid_o) begin
                if (hold_v) begin
                    check("hold_data", out_data_o, hold_d);
                    check("hold_tag", {27'd0, out_tag_o}, {27'd0, hold_t});
                end
                hold_v = 1'b1;
                hold_d = out_data_o;
                hold_t = out_tag_o;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    logic [15:0] v5_imm [8] = '{16'h0001, 16'hFFFF, 16'hFFFF, 16'h8000,
                                16'hFFFF, 16'h7FFF, 16'h0001, 16'h0000};
    logic [1:0]  v5_mode[8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b10, 2'b01};
    logic [31:0] v5_exp [8] = '{32'h00000001, 32'h0000FFFF, 32'hFFFF0000, 32'hFFFE0000,
                                32'hFFFFFFFF, 32'h0001FFFC, 32'h00010000, 32'h00000000};

    initial begin
        int base;
        n_chk = 0; n_fail = 0; n_out = 0; last_wait = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_imm = 16'd0; in_mode = 2'd0; in_tag = 5'd0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        check("rst_out_data", out_data_o, 32'd0);
        check("rst_out_tag", {27'd0, out_tag_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1-3: each mode, latency of one cycle after accept
        send(16'h8000, 2'b00, 5'd1, 32'hFFFF8000);
        check("lat_sext_neg", {31'd0, out_valid_o}, 32'd1);
        send(16'h7FFF, 2'b00, 5'd2, 32'h00007FFF);
        check("lat_sext_pos", {31'd0, out_valid_o}, 32'd1);
        send(16'h8000, 2'b01, 5'd3, 32'h00008000);
        send(16'h1234, 2'b10, 5'd4, 32'h12340000);
        send(16'hFFFF, 2'b11, 5'h1F, 32'hFFFFFFFC);
        send(16'h0001, 2'b11, 5'd6, 32'h00000004);
        drain();

        // 4: stall with two beats held, then release
        base = n_out;
        fork
            begin
                send(16'h8001, 2'b00, 5'd10, 32'hFFFF8001);
                send(16'h00AA, 2'b01, 5'd11, 32'h000000AA);
                send(16'hABCD, 2'b10, 5'd12, 32'hABCD0000);
                send(16'h4000, 2'b11, 5'd13, 32'h00010000);
            end
            begin
                out_ready = 1'b0;
                cycles(3);
                check("stall_in_ready", {31'd0, in_ready_o}, 32'd0);
                check("stall_out_data", out_data_o, 32'hFFFF8001);
                check("stall_taken", n_out - base, 32'd0);
                out_ready = 1'b1;
                base = n_out;
                cycles(4);
                check("release_no_gap", n_out - base, 32'd4);
            end
        join
        drain();

        // 5: back-to-back stream, full throughput
        base = n_out;
        for (int i = 0; i < 8; i++) begin
            send(v5_imm[i], v5_mode[i], 5'(i + 16), v5_exp[i]);
            check("stream_no_wait", last_wait, 32'd0);
        end
        cycles(1);
        check("stream_count", n_out - base, 32'd8);
        drain();

        // 6: reset while FULL
        out_ready = 1'b0;
        send(16'h1111, 2'b00, 5'd7, 32'h00001111);
        send(16'h2222, 2'b00, 5'd8, 32'h00002222);
        check("full_in_ready", {31'd0, in_ready_o}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid_o}, 32'd0);
        check("async_rst_ready", {31'd0, in_ready_o}, 32'd1);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        base = n_out;
        cycles(2);
        check("post_rst_idle", n_out - base, 32'd0);
        send(16'h0F0F, 2'b10, 5'd9, 32'h0F0F0000);
        drain();
        check("post_rst_count", n_out - base, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_imm_ext_pipe
